// File: rtl/uart_word_tx_if.sv
// -----------------------------------------------------------------------------
// uart_word_tx_if
//
// Bundles the word-side handshake and the UART byte handshake of uart_word_tx.
//
// Signals
//   word_valid  upstream -> block   32-bit result word is available
//   word_data   upstream -> block   result word, transmitted MSB byte first
//   word_ready  block -> upstream   block is idle and can take a word
//   send_data   block -> UART       one-cycle strobe, tx_data is valid
//   tx_data     block -> UART       byte to transmit
//   tx_done     UART -> block       one-cycle pulse, current byte finished
//   frame_done  block -> upstream   one-cycle pulse, whole frame acknowledged
//   tx_timeout  block -> upstream   one-cycle pulse, frame aborted by watchdog
//
// Modports
//   master  environment side (word source plus UART transmitter)
//   slave   the uart_word_tx block itself
// -----------------------------------------------------------------------------
interface uart_word_tx_if;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        send_data;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        frame_done;
    logic        tx_timeout;

    modport master (
        output word_valid,
        output word_data,
        output tx_done,
        input  word_ready,
        input  send_data,
        input  tx_data,
        input  frame_done,
        input  tx_timeout
    );

    modport slave (
        input  word_valid,
        input  word_data,
        input  tx_done,
        output word_ready,
        output send_data,
        output tx_data,
        output frame_done,
        output tx_timeout
    );
endinterface

// File: rtl/uart_word_tx.sv
// -----------------------------------------------------------------------------
// uart_word_tx
//
// Serialises one 32-bit result word (IEEE-754 single) into bytes for a UART
// transmitter, most significant byte first. Each byte is offered with a
// one-cycle send_data strobe and the block then waits for the transmitter's
// tx_done pulse before moving on. A per-byte watchdog aborts the frame if
// tx_done does not arrive within TX_TIMEOUT cycles.
//
// Parameters
//   TX_TIMEOUT  cycles spent in WAIT without tx_done before the frame is
//               aborted (must be >= 1)
//
// Ports
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    uart_word_tx_if.slave (word handshake, UART byte handshake and
//          frame status pulses)
//
// Build option
//   UART_WORD_TX_CSUM_EN  when defined, a fifth byte carrying the XOR of the
//                         four data bytes follows the last data byte; when
//                         undefined the frame is exactly four bytes and no
//                         checksum hardware is built.
// -----------------------------------------------------------------------------
module uart_word_tx #(
    parameter int unsigned TX_TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_word_tx_if.slave bus
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Watchdog only needs to reach TX_TIMEOUT-1: the cycle holding that value
    // is the last WAIT cycle in which tx_done is still accepted.
    localparam int unsigned       WDOG_W    = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TX_TIMEOUT - 1);

`ifdef UART_WORD_TX_CSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]        state_q,      state_d;
    logic [31:0]       shift_q,      shift_d;
    logic [2:0]        byte_cnt_q,   byte_cnt_d;
    logic [WDOG_W-1:0] wdog_q,       wdog_d;
    logic              frame_done_q, frame_done_d;
    logic              tx_timeout_q, tx_timeout_d;

    // Byte shifted into the low end of the shift register on every advance.
    logic [7:0]        shift_fill;

`ifdef UART_WORD_TX_CSUM_EN
    logic [7:0]        csum_q, csum_d;

    // The checksum is shifted in behind the data: after four advances it has
    // reached [31:24] and goes out as the fifth byte with no extra muxing.
    assign shift_fill = csum_q;
`else
    assign shift_fill = 8'h00;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        wdog_d       = wdog_q;
        frame_done_d = 1'b0;
        tx_timeout_d = 1'b0;
`ifdef UART_WORD_TX_CSUM_EN
        csum_d       = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // tx_done is deliberately not looked at here.
                if (bus.word_valid) begin
                    shift_d    = bus.word_data;
                    byte_cnt_d = '0;
                    state_d    = ST_SEND;
`ifdef UART_WORD_TX_CSUM_EN
                    csum_d     = bus.word_data[31:24] ^ bus.word_data[23:16]
                               ^ bus.word_data[15:8]  ^ bus.word_data[7:0];
`endif
                end
            end

            ST_SEND: begin
                // Single strobe cycle; the watchdog restarts for the byte
                // that is being handed over now.
                wdog_d  = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (bus.tx_done) begin
                    // tx_done takes priority over a watchdog expiring in the
                    // same cycle.
                    if (byte_cnt_q == LAST_IDX) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        shift_d    = {shift_q[23:0], shift_fill};
                        state_d    = ST_SEND;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    // Remaining bytes are dropped; shift register keeps its
                    // contents until the next word is accepted.
                    tx_timeout_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (wdog_q < WDOG_LAST) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            wdog_q       <= '0;
            frame_done_q <= 1'b0;
            tx_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            wdog_q       <= wdog_d;
            frame_done_q <= frame_done_d;
            tx_timeout_q <= tx_timeout_d;
        end
    end

`ifdef UART_WORD_TX_CSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // tx_data comes straight from the shift register, so it only changes on
    // the edge that enters SEND and is stable across the whole WAIT period.
    assign bus.word_ready = (state_q == ST_IDLE);
    assign bus.send_data  = (state_q == ST_SEND);
    assign bus.tx_data    = shift_q[31:24];
    assign bus.frame_done = frame_done_q;
    assign bus.tx_timeout = tx_timeout_q;

`ifndef SYNTHESIS
    // -------------------------------------------------------------------------
    // Protocol properties
    // -------------------------------------------------------------------------
    a_status_exclusive : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(bus.frame_done && bus.tx_timeout)
    );

    a_send_single_cycle : assert property (
        @(posedge clk) disable iff (!rst_n)
        bus.send_data |=> !bus.send_data
    );
`endif

endmodule

// File: tb/tb_uart_word_tx.sv
`timescale 1ns/1ps
module tb_uart_word_tx;

    localparam int EV_BYTE  = 0;
    localparam int EV_FRAME = 1;
    localparam int EV_TOUT  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    uart_word_tx_if bus_a ();
    uart_word_tx_if bus_b ();

    uart_word_tx dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    uart_word_tx #(
        .TX_TIMEOUT (16)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         gap;   // expected cycles since previous event, 0 = unchecked
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    int  last_ev [2];
    int  sends   [2];

    // UART responder controls
    int   dly_a, dly_b;          // tx_done delay after send_data, 0 = silent
    bit   ghost_a, abort_a;
    logic done_a_model = 1'b0;
    logic done_a_stim  = 1'b0;
    logic done_b_model = 1'b0;

    assign bus_a.tx_done = done_a_model | done_a_stim;
    assign bus_b.tx_done = done_b_model;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic int qsize(int id);
        return (id == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic void push(int id, int kind, logic [7:0] d, int gap);
        ev_t e;
        e.kind = kind;
        e.data = d;
        e.gap  = gap;
        if (id == 0) q_a.push_back(e);
        else         q_b.push_back(e);
    endfunction

    function automatic void push_frame(int id, logic [31:0] w, int first_gap, int dly);
        logic [7:0] cs;
        cs = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        push(id, EV_BYTE, w[31:24], first_gap);
        push(id, EV_BYTE, w[23:16], dly + 1);
        push(id, EV_BYTE, w[15:8],  dly + 1);
        push(id, EV_BYTE, w[7:0],   dly + 1);
`ifdef UART_WORD_TX_CSUM_EN
        push(id, EV_BYTE, cs,       dly + 1);
`else
        if (cs == 8'h00) begin end
`endif
        push(id, EV_FRAME, 8'h00,   dly + 1);
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    function automatic void expect_ev(int id, int kind, logic [7:0] data, logic rdy);
        ev_t   e;
        string tag;
        tag = (id == 0) ? "a" : "b";
        if (qsize(id) == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_unexpected_event: got kind %0d data %0h expected no event (cycle %0d)",
                     tag, kind, data, cyc);
        end else begin
            if (id == 0) e = q_a.pop_front();
            else         e = q_b.pop_front();
            chk({tag, "_event_kind"}, kind, e.kind);
            if (e.kind == EV_BYTE && kind == EV_BYTE)
                chk({tag, "_tx_data"}, data, e.data);
            chk({tag, "_word_ready_at_event"}, rdy, (e.kind == EV_BYTE) ? 0 : 1);
            if (e.gap != 0)
                chk({tag, "_event_gap"}, cyc - last_ev[id], e.gap);
        end
        last_ev[id] = cyc;
    endfunction

    function automatic void observe(int id, logic sd, logic [7:0] td, logic fd, logic to, logic rdy);
        if (fd || to)
            chk((id == 0) ? "a_fd_to_exclusive" : "b_fd_to_exclusive", fd && to, 0);
        if (sd) begin
            sends[id]++;
            expect_ev(id, EV_BYTE, td, rdy);
        end
        if (fd) expect_ev(id, EV_FRAME, 8'h00, rdy);
        if (to) expect_ev(id, EV_TOUT,  8'h00, rdy);
    endfunction

    always @(negedge clk) begin
        if (cyc > 0) begin
            observe(0, bus_a.send_data, bus_a.tx_data, bus_a.frame_done, bus_a.tx_timeout, bus_a.word_ready);
            observe(1, bus_b.send_data, bus_b.tx_data, bus_b.frame_done, bus_b.tx_timeout, bus_b.word_ready);
        end
    end

    // ------------------------------------------------------------------
    // UART responders
    // ------------------------------------------------------------------
    initial begin : uart_a
        int n;
        @(negedge clk);
        forever begin
            if (bus_a.send_data === 1'b1 && dly_a > 0 && !abort_a) begin
                n = dly_a;
                if (ghost_a) begin
                    // tx_done during the SEND cycle itself
                    done_a_model = 1'b1;
                    @(negedge clk);
                    done_a_model = 1'b0;
                    n = dly_a - 1;
                end
                for (int k = 0; k < n && !abort_a; k++) @(negedge clk);
                if (!abort_a) begin
                    done_a_model = 1'b1;
                    @(negedge clk);
                    done_a_model = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin : uart_b
        @(negedge clk);
        forever begin
            if (bus_b.send_data === 1'b1 && dly_b > 0) begin
                for (int k = 0; k < dly_b; k++) @(negedge clk);
                done_b_model = 1'b1;
                @(negedge clk);
                done_b_model = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------
    task automatic set_word(int id, logic v, logic [31:0] w);
        if (id == 0) begin
            bus_a.word_valid = v;
            bus_a.word_data  = w;
        end else begin
            bus_b.word_valid = v;
            bus_b.word_data  = w;
        end
    endtask

    function automatic logic rdy(int id);
        return (id == 0) ? bus_a.word_ready : bus_b.word_ready;
    endfunction

    // Leaves word_valid asserted; returns on the negedge after acceptance.
    task automatic send_word(int id, logic [31:0] w, string name);
        bit ok;
        ok = 0;
        set_word(id, 1'b1, w);
        for (int k = 0; k < 2000; k++) begin
            if (rdy(id) === 1'b1) begin
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk({name, "_accept_timeout"}, 0, 1);
    endtask

    task automatic drop_word(int id);
        set_word(id, 1'b0, 32'hDEADBEEF);
    endtask

    task automatic drain(int id, int budget, string name);
        for (int k = 0; k < budget; k++) begin
            if (qsize(id) == 0) break;
            @(negedge clk);
        end
        chk({name, "_pending_events"}, qsize(id), 0);
        repeat (30) @(negedge clk);
    endtask

    task automatic chk_reset(int id, string tag);
        if (id == 0) begin
            chk({tag, "_word_ready"}, bus_a.word_ready, 1);
            chk({tag, "_send_data"},  bus_a.send_data,  0);
            chk({tag, "_tx_data"},    bus_a.tx_data,    0);
            chk({tag, "_frame_done"}, bus_a.frame_done, 0);
            chk({tag, "_tx_timeout"}, bus_a.tx_timeout, 0);
        end else begin
            chk({tag, "_word_ready"}, bus_b.word_ready, 1);
            chk({tag, "_send_data"},  bus_b.send_data,  0);
            chk({tag, "_tx_data"},    bus_b.tx_data,    0);
            chk({tag, "_frame_done"}, bus_b.frame_done, 0);
            chk({tag, "_tx_timeout"}, bus_b.tx_timeout, 0);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : stim
        int target;
        rst_n   = 1'b0;
        dly_a   = 20;
        dly_b   = 16;
        ghost_a = 0;
        abort_a = 0;
        sends[0] = 0;   sends[1] = 0;
        last_ev[0] = 0; last_ev[1] = 0;
        set_word(0, 1'b0, 32'h0);
        set_word(1, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        chk_reset(0, "reset_a");
        chk_reset(1, "reset_b");
        rst_n = 1'b1;
        @(negedge clk);

        // pi, 20-cycle UART
        push_frame(0, 32'h40490FDB, 0, 20);
        send_word(0, 32'h40490FDB, "pi");
        drop_word(0);
        drain(0, 400, "pi");

        // two words back-to-back with word_valid held; second word's data
        // is presented while the first frame is still in flight
        push_frame(0, 32'h11223344, 0, 20);
        push_frame(0, 32'hAABBCCDD, 1, 20);
        send_word(0, 32'h11223344, "b2b_first");
        send_word(0, 32'hAABBCCDD, "b2b_second");
        drop_word(0);
        drain(0, 800, "b2b");

        // tx_done while idle
        done_a_stim = 1'b1;
        repeat (3) @(negedge clk);
        done_a_stim = 1'b0;
        @(negedge clk);
        chk("idle_txdone_word_ready", bus_a.word_ready, 1);
        chk("idle_txdone_send_data",  bus_a.send_data,  0);

        // tx_done during every SEND cycle
        ghost_a = 1;
        push_frame(0, 32'h5A3C96E1, 0, 20);
        send_word(0, 32'h5A3C96E1, "ghost");
        drop_word(0);
        drain(0, 400, "ghost");
        ghost_a = 0;

        // reset one cycle into WAIT after the second byte
        push(0, EV_BYTE, 8'hCA, 0);
        push(0, EV_BYTE, 8'hFE, 21);
        target = sends[0] + 2;
        send_word(0, 32'hCAFEF00D, "midrst");
        drop_word(0);
        for (int k = 0; k < 200; k++) begin
            if (sends[0] >= target) break;
            @(negedge clk);
        end
        chk("midrst_sends_before_reset", sends[0], target);
        @(negedge clk);
        abort_a = 1;
        rst_n   = 1'b0;
        @(negedge clk);
        chk_reset(0, "midrst_a");
        rst_n = 1'b1;
        @(negedge clk);
        abort_a = 0;
        chk("midrst_pending_events", qsize(0), 0);
        repeat (40) @(negedge clk);

        push_frame(0, 32'h3F800000, 0, 20);
        send_word(0, 32'h3F800000, "post_rst");
        drop_word(0);
        drain(0, 400, "post_rst");

        // TX_TIMEOUT=16: tx_done lands exactly on the watchdog's last cycle
        dly_b = 16;
        push_frame(1, 32'h40490FDB, 0, 16);
        send_word(1, 32'h40490FDB, "coincide");
        drop_word(1);
        drain(1, 400, "coincide");

        // TX_TIMEOUT=16: UART never answers
        dly_b = 0;
        push(1, EV_BYTE, 8'h40, 0);
        push(1, EV_TOUT, 8'h00, 17);
        send_word(1, 32'h40490FDB, "tout");
        drop_word(1);
        drain(1, 200, "tout");

        // recovery after timeout
        dly_b = 16;
        push_frame(1, 32'h01020304, 0, 16);
        send_word(1, 32'h01020304, "tout_recover");
        drop_word(1);
        drain(1, 400, "tout_recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, compared %0d mismatched %0d",
                 compared, mismatched);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 SHALL have parameter TX_TIMEOUT, default 65535, max cycles spent waiting for tx_done per byte before abort.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port word_valid  input  1  upstream has a 32-bit result ready.
REQ-005 SHALL have port word_data  input  32  result word (IEEE-754 single), sent MSB byte first.
REQ-006 SHALL have port word_ready  output  1  block can accept a word.
REQ-007 SHALL have port send_data  output  1  one-cycle strobe to UART transmitter.
REQ-008 SHALL have port tx_data  output  8  byte to transmit; valid while send_data high.
REQ-009 SHALL have port tx_done  input  1  one-cycle pulse from UART when current byte is finished.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse, last byte of frame acknowledged.
REQ-011 SHALL have port tx_timeout  output  1  one-cycle pulse, frame aborted on watchdog.

Function
REQ-012 SHALL implement states IDLE, SEND, WAIT.
REQ-013 word_ready SHALL be high exactly when state is IDLE.
REQ-014 IDLE: word_valid && word_ready at edge N captures word_data into a 32-bit shift register, clears byte counter, goes to SEND.
REQ-015 SEND: send_data high for exactly one cycle (cycle N+1 after acceptance); state goes to WAIT next edge.
REQ-016 tx_data SHALL present shift register [31:24] and stay stable from the SEND cycle until the next SEND cycle.
REQ-017 WAIT: on tx_done, if byte counter equals last index, pulse frame_done and go to IDLE; else increment counter, shift register left 8, go to SEND.
REQ-018 Byte order SHALL be word_data[31:24], [23:16], [15:8], [7:0].
REQ-019 WAIT SHALL count cycles from entry; if TX_TIMEOUT cycles elapse without tx_done, pulse tx_timeout and return to IDLE, remaining bytes discarded.
REQ-020 Watchdog counter SHALL clear on every entry to WAIT and saturate, never wrap.
REQ-021 tx_done and timeout expiry in the same cycle: tx_done wins, no tx_timeout.
REQ-022 tx_done in IDLE or SEND SHALL be ignored with no state change.
REQ-023 word_valid outside IDLE SHALL be ignored; word_data sampled only at acceptance.
REQ-024 frame_done and tx_timeout SHALL never be high in the same cycle.
REQ-025 Back-to-back: word accepted in the cycle after frame_done's IDLE return; no data byte sent twice or skipped.

Reset
REQ-026 rst_n low at a rising edge SHALL force state IDLE, counters 0, shift register 0, tx_data 8'h00, send_data 0, frame_done 0, tx_timeout 0; word_ready 1 after the first edge with rst_n high.
REQ-027 Reset mid-frame SHALL abort the frame with no frame_done or tx_timeout pulse.

Configuration
REQ-028 With UART_WORD_TX_CSUM_EN defined, a fifth byte SHALL follow [7:0]: XOR of the four data bytes, same SEND/WAIT handshake; frame_done after its tx_done.
REQ-029 Without UART_WORD_TX_CSUM_EN, frame SHALL be exactly four bytes and no checksum logic SHALL exist.

Verification
REQ-030 word_data 32'h40490FDB, tx_done 20 cycles after each send_data -> send_data pulses with tx_data 40,49,0F,DB; frame_done once after 4th tx_done (with CSUM_EN: fifth byte DD, frame_done after it).
REQ-031 TX_TIMEOUT=16, no tx_done after first send_data -> tx_timeout one cycle, 16 cycles into WAIT; word_ready high next cycle; no frame_done.
REQ-032 rst_n low for 1 cycle after second byte's send_data -> all outputs at reset values; next word 32'h3F800000 sends 3F,80,00,00 cleanly.
REQ-033 Two words 32'h11223344 and 32'hAABBCCDD, word_valid held high -> bytes 11,22,33,44,AA,BB,CC,DD in order; two frame_done pulses.
REQ-034 tx_done pulsed in IDLE and in SEND cycle -> no state change, no extra send_data; tx_done coinciding with watchdog terminal cycle -> byte advances, no tx_timeout.
